// File: rtl/rom_bsram_mem_bridge.sv
// Bridges the mapper's ROM and BSRAM buses onto one shared 16-bit request/ack memory port.
// Keeps a one-word ROM read cache and a one-deep BSRAM write buffer.
module rom_bsram_mem_bridge #(
    parameter logic [23:0] BSRAM_BASE   = 24'hE00000,
    parameter bit          ROM_CACHE_EN = 1'b1
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [22:0] rom_addr,
    input  logic        rom_ce_n,
    input  logic        rom_oe_n,
    input  logic        rom_word,
    output logic [15:0] rom_q,
    input  logic [19:0] bsram_addr,
    input  logic [7:0]  bsram_d,
    input  logic        bsram_ce_n,
    input  logic        bsram_oe_n,
    input  logic        bsram_we_n,
    output logic [7:0]  bsram_q,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ROM_RD, BS_RD, BS_WR} state_t;
    state_t state, state_next;

    logic        rom_act, bs_rd_act, rom_trig, bs_rd_trig, wr_trig;
    logic        prev_rom_act, prev_rom_word, prev_bs_rd_act, prev_we_n;
    logic [22:0] prev_rom_addr;
    logic [19:0] prev_bs_addr;

    logic        cache_vld, cache_hit;
    logic [21:0] cache_tag;
    logic [15:0] cache_data;

    logic        rom_pend, rom_pend_word, bs_pend, wr_pend;
    logic [22:0] rom_pend_addr, req_rom_addr;
    logic        req_rom_word, req_bs_a0;
    logic [19:0] bs_pend_addr, wr_addr;
    logic [7:0]  wr_data;
    logic        take_wr, take_rom, take_bs, ack_ok;

    function automatic logic [15:0] fmt_rom(input logic [15:0] w, input logic a0, input logic word);
        if (word) return w;
        return a0 ? {w[15:8], w[15:8]} : {w[7:0], w[7:0]};
    endfunction

    assign rom_act    = !rom_ce_n && !rom_oe_n;
    assign bs_rd_act  = !bsram_ce_n && !bsram_oe_n && bsram_we_n;
    assign rom_trig   = rom_act && (!prev_rom_act || rom_addr != prev_rom_addr || rom_word != prev_rom_word);
    assign bs_rd_trig = bs_rd_act && (!prev_bs_rd_act || bsram_addr != prev_bs_addr);
    assign wr_trig    = prev_we_n && !bsram_we_n && !bsram_ce_n;
    assign cache_hit  = ROM_CACHE_EN && cache_vld && (cache_tag == rom_addr[22:1]);
    assign ack_ok     = mem_req && mem_ack && (state != IDLE);
    assign busy       = (state != IDLE) || wr_pend;

    // Pending reads are only issued while their strobe is still asserted.
    always_comb begin
        state_next = state;
        take_wr    = 1'b0;
        take_rom   = 1'b0;
        take_bs    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    state_next = BS_WR;
                    take_wr    = 1'b1;
                end else if (rom_pend && rom_act) begin
                    state_next = ROM_RD;
                    take_rom   = 1'b1;
                end else if (bs_pend && bs_rd_act) begin
                    state_next = BS_RD;
                    take_bs    = 1'b1;
                end
            end
            default: if (ack_ok) state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            rom_q          <= '0;
            bsram_q        <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            prev_rom_act   <= 1'b0;
            prev_rom_word  <= 1'b0;
            prev_rom_addr  <= '0;
            prev_bs_rd_act <= 1'b0;
            prev_bs_addr   <= '0;
            prev_we_n      <= 1'b1;
            cache_vld      <= 1'b0;
            cache_tag      <= '0;
            cache_data     <= '0;
            rom_pend       <= 1'b0;
            rom_pend_addr  <= '0;
            rom_pend_word  <= 1'b0;
            bs_pend        <= 1'b0;
            bs_pend_addr   <= '0;
            wr_pend        <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            req_rom_addr   <= '0;
            req_rom_word   <= 1'b0;
            req_bs_a0      <= 1'b0;
        end else begin
            prev_rom_act   <= rom_act;
            prev_rom_addr  <= rom_addr;
            prev_rom_word  <= rom_word;
            prev_bs_rd_act <= bs_rd_act;
            prev_bs_addr   <= bsram_addr;
            prev_we_n      <= bsram_we_n;

            if (wr_trig) begin
                wr_pend <= 1'b1;
                wr_addr <= bsram_addr;
                wr_data <= bsram_d;
            end else if (take_wr) begin
                wr_pend <= 1'b0;
            end

            if (take_wr) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= BSRAM_BASE + {4'd0, wr_addr};
                mem_be    <= wr_addr[0] ? 2'b10 : 2'b01;
                mem_wdata <= {wr_data, wr_data};
            end else if (take_rom) begin
                mem_req      <= 1'b1;
                mem_we       <= 1'b0;
                mem_addr     <= {1'b0, rom_pend_addr[22:1], 1'b0};
                mem_be       <= 2'b11;
                req_rom_addr <= rom_pend_addr;
                req_rom_word <= rom_pend_word;
            end else if (take_bs) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= BSRAM_BASE + {4'd0, bs_pend_addr};
                mem_be    <= bs_pend_addr[0] ? 2'b10 : 2'b01;
                req_bs_a0 <= bs_pend_addr[0];
            end

            if (ack_ok) begin
                mem_req <= 1'b0;
                if (state == ROM_RD) begin
                    cache_vld  <= 1'b1;
                    cache_tag  <= req_rom_addr[22:1];
                    cache_data <= mem_rdata;
                    rom_q      <= fmt_rom(mem_rdata, req_rom_addr[0], req_rom_word);
                end else if (state == BS_RD) begin
                    bsram_q <= req_bs_a0 ? mem_rdata[15:8] : mem_rdata[7:0];
                end
            end

            // A fresh hit reflects the newest address, so it overrides a same-cycle fill.
            if (rom_trig && cache_hit) begin
                rom_q    <= fmt_rom(cache_data, rom_addr[0], rom_word);
                rom_pend <= 1'b0;
            end else if (rom_trig) begin
                rom_pend      <= 1'b1;
                rom_pend_addr <= rom_addr;
                rom_pend_word <= rom_word;
            end else if (take_rom || !rom_act) begin
                rom_pend <= 1'b0;
            end

            if (bs_rd_trig) begin
                bs_pend      <= 1'b1;
                bs_pend_addr <= bsram_addr;
            end else if (take_bs || !bs_rd_act) begin
                bs_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_bsram_mem_bridge.sv
// Scoreboard bench: stimulus pushes expected memory requests and read data; a monitor pops and compares.
// A second, cache-disabled instance checks that every ROM access reaches memory.
module tb_rom_bsram_mem_bridge;
    localparam logic [23:0] BASE = 24'hFFFFF0;

    logic        mclk = 1'b0;
    logic        rst;
    logic [22:0] rom_addr;
    logic        rom_ce_n, rom_oe_n, rom_word;
    logic [15:0] rom_q, rom_q_nc;
    logic [19:0] bsram_addr;
    logic [7:0]  bsram_d, bsram_q, bsram_q_nc;
    logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic        mem_req, mem_we, mem_ack, busy;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_req_nc, mem_we_nc, mem_ack_nc, busy_nc;
    logic [23:0] mem_addr_nc;
    logic [1:0]  mem_be_nc;
    logic [15:0] mem_wdata_nc, mem_rdata_nc;

    always #5 mclk = ~mclk;

    rom_bsram_mem_bridge #(.BSRAM_BASE(BASE), .ROM_CACHE_EN(1'b1)) dut (
        .mclk(mclk), .rst(rst), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .rom_q(rom_q), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n), .bsram_q(bsram_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy));

    rom_bsram_mem_bridge #(.ROM_CACHE_EN(1'b0)) dut_nc (
        .mclk(mclk), .rst(rst), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .rom_word(rom_word), .rom_q(rom_q_nc), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n), .bsram_q(bsram_q_nc),
        .mem_req(mem_req_nc), .mem_we(mem_we_nc), .mem_addr(mem_addr_nc), .mem_be(mem_be_nc),
        .mem_wdata(mem_wdata_nc), .mem_rdata(mem_rdata_nc), .mem_ack(mem_ack_nc), .busy(busy_nc));

    typedef struct {
        logic [23:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
        int          kind;   // 0 ROM read, 1 BSRAM read, 2 BSRAM write
    } req_t;

    req_t        req_q[$];
    logic [15:0] rom_exp_q[$];
    logic [7:0]  bs_exp_q[$];
    logic [15:0] mem [int];

    int checks = 0, fails = 0;
    int main_req_cnt = 0, nc_req_cnt = 0;
    int delay = 3, cnt = 0;
    bit stall = 0, force_ack = 0, rand_delay = 0;

    logic        cvld = 1'b0;
    logic [21:0] ctag = '0;
    logic [15:0] cdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [22:0] wi);
        if (mem.exists(int'(wi))) return mem[int'(wi)];
        return wi[15:0] ^ 16'h3C96 ^ {9'd0, wi[22:16]};
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] w, input logic a0, input logic word);
        if (word) return w;
        return a0 ? {2{w[15:8]}} : {2{w[7:0]}};
    endfunction

    function automatic req_t mk_req(input logic [23:0] a, input logic [1:0] be, input logic we,
                                    input logic [15:0] wd, input int kind);
        req_t r;
        r.addr = a; r.be = be; r.we = we; r.wdata = wd; r.kind = kind;
        return r;
    endfunction

    // Backing memory for the main instance.
    initial begin
        logic [15:0] w;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge mclk); #1;
            if (mem_ack) mem_ack = 1'b0;
            else if (force_ack) begin
                mem_ack = 1'b1; mem_rdata = 16'hDEAD; force_ack = 0; cnt = 0;
            end else if (mem_req && !stall) begin
                if (cnt >= delay) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    if (mem_we) begin
                        w = rd_word(mem_addr[23:1]);
                        if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
                        if (mem_be[1]) w[15:8] = mem_wdata[15:8];
                        mem[int'(mem_addr[23:1])] = w;
                    end else begin
                        mem_rdata = rd_word(mem_addr[23:1]);
                    end
                    if (rand_delay) delay = int'($urandom_range(0, 3));
                end else cnt++;
            end
        end
    end

    // Single-cycle responder for the cache-disabled instance; counts its requests.
    initial begin
        bit prev;
        prev = 0;
        mem_ack_nc = 1'b0;
        mem_rdata_nc = 16'h1234;
        forever begin
            @(posedge mclk); #1;
            if (mem_req_nc && !prev) nc_req_cnt++;
            prev = mem_req_nc;
            if (mem_ack_nc) mem_ack_nc = 1'b0;
            else if (mem_req_nc) mem_ack_nc = 1'b1;
        end
    end

    // Monitor: request contents on the rising mem_req, stability while held, read data after ack.
    initial begin
        req_t cur;
        int   pend_kind;
        bit   prev_req;
        cur = mk_req('0, '0, 1'b0, '0, -1);
        pend_kind = -1;
        prev_req = 0;
        forever begin
            @(negedge mclk);
            if (pend_kind == 0) begin
                if (rom_exp_q.size() != 0) chk("rom_q", 32'(rom_q), 32'(rom_exp_q.pop_front()));
                else chk("rom_exp_available", 0, 1);
            end else if (pend_kind == 1) begin
                if (bs_exp_q.size() != 0) chk("bsram_q", 32'(bsram_q), 32'(bs_exp_q.pop_front()));
                else chk("bs_exp_available", 0, 1);
            end
            pend_kind = -1;
            if (mem_req && !prev_req) begin
                main_req_cnt++;
                if (req_q.size() == 0) begin
                    chk("unexpected_req_addr", 32'(mem_addr), 32'hFFFFFFFF);
                    cur = mk_req(mem_addr, mem_be, mem_we, mem_wdata, -1);
                end else begin
                    cur = req_q.pop_front();
                    chk("req_addr", 32'(mem_addr), 32'(cur.addr));
                    chk("req_be", 32'(mem_be), 32'(cur.be));
                    chk("req_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
            end else if (mem_req) begin
                chk("req_stable", {5'd0, mem_addr, mem_be, mem_we}, {5'd0, cur.addr, cur.be, cur.we});
            end
            if (mem_req && mem_ack) pend_kind = cur.kind;
            prev_req = mem_req;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        tick(2);
        while ((busy || mem_req || req_q.size() != 0 || rom_exp_q.size() != 0 || bs_exp_q.size() != 0) && k < 80) begin
            tick(1);
            k++;
        end
        chk("idle_reached", {30'd0, busy, mem_req}, 0);
    endtask

    task automatic expect_rom(input logic [22:0] a, input logic w, output logic hit, output logic [15:0] q);
        logic [15:0] d;
        hit = cvld && ctag == a[22:1];
        d = hit ? cdata : rd_word({1'b0, a[22:1]});
        q = fmt(d, a[0], w);
        if (!hit) begin
            req_q.push_back(mk_req({1'b0, a[22:1], 1'b0}, 2'b11, 1'b0, 16'h0, 0));
            rom_exp_q.push_back(q);
            cvld = 1'b1; ctag = a[22:1]; cdata = d;
        end
    endtask

    task automatic rom_read(input logic [22:0] a, input logic w);
        logic hit;
        logic [15:0] q;
        int c0;
        expect_rom(a, w, hit, q);
        c0 = main_req_cnt;
        rom_addr = a; rom_word = w; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        if (hit) begin
            tick(1);
            chk("rom_hit_q", 32'(rom_q), 32'(q));
        end
        wait_idle();
        if (hit) chk("rom_hit_no_req", main_req_cnt, c0);
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        tick(1);
    endtask

    function automatic logic [23:0] bs_mem_addr(input logic [19:0] a);
        return BASE + {4'd0, a};
    endfunction

    task automatic wr_pulse(input logic [19:0] a, input logic [7:0] d);
        bsram_addr = a; bsram_d = d; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
        tick(1);
        bsram_we_n = 1'b1; bsram_ce_n = 1'b1;
        tick(1);
    endtask

    task automatic bs_write(input logic [19:0] a, input logic [7:0] d);
        logic [23:0] ma;
        ma = bs_mem_addr(a);
        req_q.push_back(mk_req(ma, ma[0] ? 2'b10 : 2'b01, 1'b1, {d, d}, 2));
        bsram_addr = a; bsram_d = d; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
        wait_idle();
        bsram_we_n = 1'b1; bsram_ce_n = 1'b1;
        tick(1);
        chk("bs_wr_busy_after", 32'(busy), 0);
    endtask

    task automatic bs_read(input logic [19:0] a);
        logic [23:0] ma;
        logic [15:0] w;
        ma = bs_mem_addr(a);
        w = rd_word(ma[23:1]);
        req_q.push_back(mk_req(ma, ma[0] ? 2'b10 : 2'b01, 1'b0, 16'h0, 1));
        bs_exp_q.push_back(ma[0] ? w[15:8] : w[7:0]);
        bsram_addr = a; bsram_ce_n = 1'b0; bsram_oe_n = 1'b0; bsram_we_n = 1'b1;
        wait_idle();
        bsram_ce_n = 1'b1; bsram_oe_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !mem_req; k++) tick(1);
        chk("req_seen", 32'(mem_req), 1);
    endtask

    initial begin
        int nc0;
        logic hit;
        logic [15:0] q;
        rst = 1'b1;
        rom_addr = '0; rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_word = 1'b0;
        bsram_addr = '0; bsram_d = '0; bsram_ce_n = 1'b1; bsram_oe_n = 1'b1; bsram_we_n = 1'b1;
        tick(3);
        chk("rst_rom_q", 32'(rom_q), 0);
        chk("rst_bsram_q", 32'(bsram_q), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick(1);

        // ROM miss then hits; the uncached instance must go to memory every time.
        mem[int'(23'h80)] = 16'hBEEF;
        delay = 3;
        nc0 = nc_req_cnt;
        rom_read(23'h000100, 1'b1);
        chk("rom_q_beef", 32'(rom_q), 32'hBEEF);
        rom_read(23'h000101, 1'b0);
        chk("rom_q_bebe", 32'(rom_q), 32'hBEBE);
        rom_read(23'h000100, 1'b1);
        tick(4);
        chk("nc_reqs", nc_req_cnt - nc0, 3);

        bs_write(20'h00003, 8'h5A);

        // Write and ROM miss triggered in the same cycle: write goes first.
        req_q.push_back(mk_req(bs_mem_addr(20'h00010), 2'b01, 1'b1, 16'h7777, 2));
        expect_rom(23'h000200, 1'b1, hit, q);
        bsram_addr = 20'h00010; bsram_d = 8'h77; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
        rom_addr = 23'h000200; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_idle();
        bsram_we_n = 1'b1; bsram_ce_n = 1'b1; rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        tick(1);
        chk("simul_rom_q", 32'(rom_q), 32'(q));

        // BSRAM window wraps through 2^24.
        mem[int'(23'h000008)] = 16'h00C3;
        bs_read(20'h00020);
        chk("bs_wrap_q", 32'(bsram_q), 32'hC3);

        // Two writes while the FSM is busy: only the last one reaches memory.
        stall = 1;
        expect_rom(23'h100004, 1'b1, hit, q);
        rom_addr = 23'h100004; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_req();
        wr_pulse(20'h00040, 8'h11);
        wr_pulse(20'h00041, 8'h22);
        req_q.push_back(mk_req(bs_mem_addr(20'h00041), 2'b10, 1'b1, 16'h2222, 2));
        stall = 0;
        wait_idle();
        rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        tick(1);
        bs_read(20'h00041);
        chk("last_write_q", 32'(bsram_q), 32'h22);
        bs_read(20'h00040);

        // Reset during an outstanding request, then an orphan ack.
        stall = 1;
        req_q.push_back(mk_req(24'h100008, 2'b11, 1'b0, 16'h0, 0));
        rom_addr = 23'h100008; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
        wait_req();
        rst = 1'b1; rom_ce_n = 1'b1; rom_oe_n = 1'b1;
        tick(1);
        chk("rst_mid_req_drop", 32'(mem_req), 0);
        tick(1);
        rst = 1'b0;
        cvld = 1'b0;
        force_ack = 1;
        tick(3);
        chk("orphan_ack_rom_q", 32'(rom_q), 0);
        chk("orphan_ack_busy", 32'(busy), 0);
        stall = 0; cnt = 0;
        nc0 = main_req_cnt;
        rom_read(23'h100008, 1'b1);
        chk("post_rst_miss", main_req_cnt - nc0, 1);

        // Randomized mix against the reference model.
        rand_delay = 1;
        for (int i = 0; i < 150; i++) begin
            logic [19:0] ba;
            ba = ($urandom_range(0, 1) != 0) ? 20'($urandom_range(0, 63)) : 20'($urandom);
            case ($urandom_range(0, 2))
                0: rom_read(23'h100000 + 23'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                1: bs_write(ba, 8'($urandom));
                default: bs_read(ba);
            endcase
        end

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
